uex_mutex_bank: RTL and testbench
=================================

# uex_mutex_bank

Hardware mutex service for uex execution cores: a parametrised bank of N_MUTEX non-recursive mutexes shared by up to N_THREADS thread IDs, with blocking lock, try-lock and unlock operations. Blocked lockers queue in per-mutex waiter bitmaps. On unlock, ownership passes directly to the next waiter, chosen round-robin, and that waiter receives a deferred grant response. The block sits behind the uex thread/sys services as the hardware backing for mutex objects.

## Interface
Parameters:
- N_MUTEX, 4, number of mutexes (≥1)
- N_THREADS, 8, number of thread IDs (≥2)
- MID_W, $clog2(N_MUTEX) (min 1), mutex-index width
- TID_W, $clog2(N_THREADS) (min 1), thread-ID width

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts request
- req_op  in  2  0=LOCK, 1=TRYLOCK, 2=UNLOCK, 3=reserved
- req_tid  in  TID_W  requesting thread
- req_mid  in  MID_W  target mutex
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_op  out  2  op being answered (LOCK for handoff grants)
- rsp_tid  out  TID_W  thread the response is addressed to
- rsp_mid  out  MID_W  mutex
- rsp_status  out  2  0=OK, 1=BUSY, 2=ERR
- mutex_locked  out  N_MUTEX  per-mutex locked flag

## Operation
- State per mutex: locked bit, owner[TID_W], wait[N_THREADS] bitmap, rr_last[TID_W].
- FSM: IDLE, RSP, GRANT. req_ready = (state==IDLE) && !reset.
- The request is evaluated in the acceptance cycle. All state updates commit on that edge.
- LOCK, mutex free: owner←tid, locked←1, response OK.
- LOCK, owned by the same tid: response ERR, no state change.
- LOCK, tid already waiting on this mutex: response ERR.
- LOCK, owned by another tid: wait[tid]←1, no response, FSM stays IDLE. The thread is blocked until a handoff.
- TRYLOCK, free: behaves as a granting LOCK, response OK. Owned by anyone, including the same tid: response BUSY, no state change.
- UNLOCK, tid==owner with wait≠0:
  - Select the next waiter round-robin, searching tids rr_last+1 upward with wrap.
  - owner←waiter, wait[waiter]←0, rr_last←waiter, locked stays 1.
  - Response OK to the unlocker, then GRANT.
- UNLOCK, tid==owner with wait==0: locked←0, response OK.
- UNLOCK when unlocked or tid≠owner: response ERR.
- op=3: response ERR, no state change.
- GRANT presents rsp_op=LOCK, rsp_tid=waiter, rsp_mid, status OK.
- Each mutex is independent. A waiter bit on one mutex never affects another.

## Timing
- Reset values:
  - state=IDLE, rsp_valid=0.
  - rsp_op/tid/mid/status = 0.
  - All locked=0, owner=0, wait=0, rr_last=N_THREADS-1 (first search starts at tid 0).
  - mutex_locked=0. req_ready=0 while reset is high and 1 on the first cycle after.
- Request handshake: req_valid && req_ready at edge k.
  - If a response is due, rsp_valid=1 from cycle k+1.
  - If blocked, req_ready=1 again at k+1.
- Response handshake: rsp_valid and all rsp_* fields hold stable until the rsp_valid && rsp_ready edge.
  - If no grant is pending, the FSM returns to IDLE and req_ready=1 the next cycle.
  - If a grant is pending, the FSM enters GRANT and the grant response is valid the next cycle. req_ready stays 0 until the grant is accepted.
- Throughput: at most one request every 2 cycles with rsp_ready tied high. A blocked LOCK takes 1 cycle.
- mutex_locked reflects committed state, updating on the acceptance edge.
- Reset asserted mid-operation, including in RSP or GRANT: all pending responses and waiters are discarded, with no response issued after reset.
- Round-robin wrap: a search from rr_last=N_THREADS-1 starts at tid 0. If the only waiter equals rr_last, it is still selected.

## Test plan
- Basic ownership: LOCK(t1,m0) → OK, mutex_locked=0001. TRYLOCK(t2,m0) → BUSY. UNLOCK(t2,m0) → ERR. UNLOCK(t1,m0) → OK, mutex_locked=0000.
- Handoff: t0 LOCK m2 → OK. t3 LOCK m2 blocks with no response and req_ready high next cycle. t0 UNLOCK m2 → OK(t0), then grant (LOCK,t3,m2,OK). Owner is now t3 and mutex_locked[2] stays 1.
- Round-robin fairness:
  - t7 owns m1; t2, t5, t6 wait.
  - Successive owner UNLOCKs grant t2, then t5, then t6.
  - With t0 and t6 waiting and rr_last=6, the next grant goes to t0 (wrap).
- Errors: recursive LOCK(t4,m3) by owner → ERR. Duplicate blocked LOCK by a waiter → ERR. op=3 → ERR. No state change in any case.
- Backpressure: rsp_ready held 0 for 5 cycles during the unlocker response and again during the grant. Fields are stable and req_ready=0 throughout, and there is no response loss or duplication.
- Reset mid-grant: assert reset during GRANT. Afterward rsp_valid=0, mutex_locked=0, all waiters are cleared, and a fresh LOCK(t0,m0) → OK.

Source files
------------

// File: rtl/uex_mutex_bank.sv
// Bank of non-recursive hardware mutexes with blocking lock, try-lock and unlock.
// Blocked lockers queue per mutex; unlock hands ownership to the next waiter round-robin.
module uex_mutex_bank #(
  parameter int N_MUTEX   = 4,
  parameter int N_THREADS = 8,
  parameter int MID_W     = (N_MUTEX > 1) ? $clog2(N_MUTEX) : 1,
  parameter int TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [TID_W-1:0]   req_tid,
  input  logic [MID_W-1:0]   req_mid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_op,
  output logic [TID_W-1:0]   rsp_tid,
  output logic [MID_W-1:0]   rsp_mid,
  output logic [1:0]         rsp_status,
  output logic [N_MUTEX-1:0] mutex_locked
);

  localparam logic [1:0] OP_LOCK   = 2'd0;
  localparam logic [1:0] OP_TRY    = 2'd1;
  localparam logic [1:0] OP_UNLOCK = 2'd2;
  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  typedef enum logic [1:0] {IDLE, RSP, GRANT} state_t;

  state_t             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_op_q, rsp_op_d;
  logic [TID_W-1:0]   rsp_tid_q, rsp_tid_d;
  logic [MID_W-1:0]   rsp_mid_q, rsp_mid_d;
  logic [1:0]         rsp_status_q, rsp_status_d;
  logic               gnt_pend_q, gnt_pend_d;
  logic [TID_W-1:0]   gnt_tid_q, gnt_tid_d;
  logic [MID_W-1:0]   gnt_mid_q, gnt_mid_d;

  logic               locked_q [N_MUTEX];
  logic               locked_d [N_MUTEX];
  logic [TID_W-1:0]   owner_q  [N_MUTEX];
  logic [TID_W-1:0]   owner_d  [N_MUTEX];
  logic [N_THREADS-1:0] wait_q [N_MUTEX];
  logic [N_THREADS-1:0] wait_d [N_MUTEX];
  logic [TID_W-1:0]   rr_q     [N_MUTEX];
  logic [TID_W-1:0]   rr_d     [N_MUTEX];

  // First set bit strictly after 'last', wrapping; 'last' itself is tried last.
  function automatic logic [TID_W-1:0] rr_pick(input logic [N_THREADS-1:0] w,
                                                input logic [TID_W-1:0]     last);
    logic [TID_W-1:0] r;
    logic [TID_W-1:0] ix;
    logic             found;
    int               idx;
    r     = last;
    found = 1'b0;
    for (int i = 1; i <= N_THREADS; i++) begin
      idx = int'(last) + i;
      if (idx >= N_THREADS) idx = idx - N_THREADS;
      ix = TID_W'(idx);
      if (!found && w[ix]) begin
        r     = ix;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic             cur_locked;
  logic [TID_W-1:0] cur_owner;
  logic [N_THREADS-1:0] cur_wait;
  logic [TID_W-1:0] nxt_tid;
  logic             respond;
  logic [1:0]       status;

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_tid_d    = rsp_tid_q;
    rsp_mid_d    = rsp_mid_q;
    rsp_status_d = rsp_status_q;
    gnt_pend_d   = gnt_pend_q;
    gnt_tid_d    = gnt_tid_q;
    gnt_mid_d    = gnt_mid_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    wait_d       = wait_q;
    rr_d         = rr_q;
    cur_locked   = locked_q[req_mid];
    cur_owner    = owner_q[req_mid];
    cur_wait     = wait_q[req_mid];
    nxt_tid      = rr_pick(cur_wait, rr_q[req_mid]);
    respond      = 1'b1;
    status       = ST_ERR;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_LOCK: begin
              if (!cur_locked) begin
                locked_d[req_mid] = 1'b1;
                owner_d[req_mid]  = req_tid;
                status            = ST_OK;
              end else if (cur_owner == req_tid || cur_wait[req_tid]) begin
                status = ST_ERR;
              end else begin
                wait_d[req_mid][req_tid] = 1'b1;
                respond                  = 1'b0;
              end
            end
            OP_TRY: begin
              if (!cur_locked) begin
                locked_d[req_mid] = 1'b1;
                owner_d[req_mid]  = req_tid;
                status            = ST_OK;
              end else begin
                status = ST_BUSY;
              end
            end
            OP_UNLOCK: begin
              if (cur_locked && cur_owner == req_tid) begin
                status = ST_OK;
                if (cur_wait != '0) begin
                  // Ownership moves now; the waiter hears about it after the unlocker.
                  owner_d[req_mid]         = nxt_tid;
                  wait_d[req_mid][nxt_tid] = 1'b0;
                  rr_d[req_mid]            = nxt_tid;
                  gnt_pend_d               = 1'b1;
                  gnt_tid_d                = nxt_tid;
                  gnt_mid_d                = req_mid;
                end else begin
                  locked_d[req_mid] = 1'b0;
                end
              end
            end
            default: status = ST_ERR;
          endcase
          if (respond) begin
            rsp_valid_d  = 1'b1;
            rsp_op_d     = req_op;
            rsp_tid_d    = req_tid;
            rsp_mid_d    = req_mid;
            rsp_status_d = status;
            state_d      = RSP;
          end
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (gnt_pend_q) begin
            rsp_op_d     = OP_LOCK;
            rsp_tid_d    = gnt_tid_q;
            rsp_mid_d    = gnt_mid_q;
            rsp_status_d = ST_OK;
            gnt_pend_d   = 1'b0;
            state_d      = GRANT;
          end else begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      GRANT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_tid_q    <= '0;
      rsp_mid_q    <= '0;
      rsp_status_q <= '0;
      gnt_pend_q   <= 1'b0;
      gnt_tid_q    <= '0;
      gnt_mid_q    <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_tid_q    <= rsp_tid_d;
      rsp_mid_q    <= rsp_mid_d;
      rsp_status_q <= rsp_status_d;
      gnt_pend_q   <= gnt_pend_d;
      gnt_tid_q    <= gnt_tid_d;
      gnt_mid_q    <= gnt_mid_d;
    end
  end

  for (genvar gi = 0; gi < N_MUTEX; gi++) begin : g_mutex
    always_ff @(posedge clock) begin
      if (reset) begin
        locked_q[gi] <= 1'b0;
        owner_q[gi]  <= '0;
        wait_q[gi]   <= '0;
        rr_q[gi]     <= TID_W'(N_THREADS - 1);
      end else begin
        locked_q[gi] <= locked_d[gi];
        owner_q[gi]  <= owner_d[gi];
        wait_q[gi]   <= wait_d[gi];
        rr_q[gi]     <= rr_d[gi];
      end
    end
    assign mutex_locked[gi] = locked_q[gi];
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_tid    = rsp_tid_q;
  assign rsp_mid    = rsp_mid_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_uex_mutex_bank.sv
// Directed bench for uex_mutex_bank: ownership, handoff, round-robin, errors,
// backpressure and reset during a pending grant.
module tb_uex_mutex_bank;
  localparam logic [1:0] LK = 2'd0, TR = 2'd1, UL = 2'd2, RSV = 2'd3;
  localparam logic [1:0] OK = 2'd0, BUSY = 2'd1, ERR = 2'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_tid;
  logic [1:0] req_mid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_op;
  logic [2:0] rsp_tid;
  logic [1:0] rsp_mid;
  logic [1:0] rsp_status;
  logic [3:0] mutex_locked;

  int n_vec = 0;
  int n_err = 0;

  uex_mutex_bank #(.N_MUTEX(4), .N_THREADS(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tid(req_tid), .req_mid(req_mid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_tid(rsp_tid), .rsp_mid(rsp_mid), .rsp_status(rsp_status),
    .mutex_locked(mutex_locked)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send(input string tag, input logic [1:0] op, input logic [2:0] tid,
                      input logic [1:0] mid);
    req_valid = 1'b1; req_op = op; req_tid = tid; req_mid = mid;
    @(negedge clock);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    $display("req  %s op=%0d tid=%0d mid=%0d", tag, op, tid, mid);
  endtask

  task automatic expect_rsp(input string tag, input logic [1:0] op, input logic [2:0] tid,
                            input logic [1:0] mid, input logic [1:0] st);
    @(negedge clock);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_op"}, 32'(rsp_op), 32'(op));
    check({tag, ".rsp_tid"}, 32'(rsp_tid), 32'(tid));
    check({tag, ".rsp_mid"}, 32'(rsp_mid), 32'(mid));
    check({tag, ".rsp_status"}, 32'(rsp_status), 32'(st));
    check({tag, ".req_ready_lo"}, 32'(req_ready), 32'd0);
    $display("rsp  %s op=%0d tid=%0d mid=%0d status=%0d", tag, rsp_op, rsp_tid, rsp_mid, rsp_status);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic hold_rsp(input string tag, input logic [1:0] op, input logic [2:0] tid,
                          input logic [1:0] mid, input logic [1:0] st);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_fields"}, {24'd0, rsp_op, rsp_tid, rsp_mid, rsp_status},
            {24'd0, op, tid, mid, st});
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    $display("hold %s 5 cycles", tag);
  endtask

  task automatic expect_blocked(input string tag);
    @(negedge clock);
    check({tag, ".no_rsp"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
    $display("blk  %s", tag);
    @(posedge clock); #1;
  endtask

  task automatic expect_idle(input string tag, input logic [3:0] locked);
    @(negedge clock);
    check({tag, ".idle_rsp"}, 32'(rsp_valid), 32'd0);
    check({tag, ".locked"}, 32'(mutex_locked), 32'(locked));
    $display("idle %s locked=%b", tag, mutex_locked);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_tid = '0; req_mid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.locked", 32'(mutex_locked), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst.req_ready_after", 32'(req_ready), 32'd1);
    check("rst.rsp_fields", {24'd0, rsp_op, rsp_tid, rsp_mid, rsp_status}, 32'd0);
    @(posedge clock); #1;

    // Basic ownership
    send("b1", LK, 3'd1, 2'd0); expect_rsp("b1", LK, 3'd1, 2'd0, OK);
    expect_idle("b1", 4'b0001);
    send("b2", TR, 3'd2, 2'd0); expect_rsp("b2", TR, 3'd2, 2'd0, BUSY);
    send("b3", UL, 3'd2, 2'd0); expect_rsp("b3", UL, 3'd2, 2'd0, ERR);
    send("b4", UL, 3'd1, 2'd0); expect_rsp("b4", UL, 3'd1, 2'd0, OK);
    expect_idle("b4", 4'b0000);

    // Handoff
    send("h1", LK, 3'd0, 2'd2); expect_rsp("h1", LK, 3'd0, 2'd2, OK);
    send("h2", LK, 3'd3, 2'd2); expect_blocked("h2");
    send("h3", UL, 3'd0, 2'd2); expect_rsp("h3", UL, 3'd0, 2'd2, OK);
    expect_rsp("h3g", LK, 3'd3, 2'd2, OK);
    expect_idle("h3", 4'b0100);
    send("h4", UL, 3'd0, 2'd2); expect_rsp("h4", UL, 3'd0, 2'd2, ERR);
    send("h5", UL, 3'd3, 2'd2); expect_rsp("h5", UL, 3'd3, 2'd2, OK);
    expect_idle("h5", 4'b0000);

    // Round-robin on m1
    send("r1", LK, 3'd7, 2'd1); expect_rsp("r1", LK, 3'd7, 2'd1, OK);
    send("r2", LK, 3'd2, 2'd1); expect_blocked("r2");
    send("r3", LK, 3'd5, 2'd1); expect_blocked("r3");
    send("r4", LK, 3'd6, 2'd1); expect_blocked("r4");
    send("r5", UL, 3'd7, 2'd1); expect_rsp("r5", UL, 3'd7, 2'd1, OK);
    expect_rsp("r5g", LK, 3'd2, 2'd1, OK);
    send("r6", UL, 3'd2, 2'd1); expect_rsp("r6", UL, 3'd2, 2'd1, OK);
    expect_rsp("r6g", LK, 3'd5, 2'd1, OK);
    send("r7", UL, 3'd5, 2'd1); expect_rsp("r7", UL, 3'd5, 2'd1, OK);
    expect_rsp("r7g", LK, 3'd6, 2'd1, OK);
    send("r8", UL, 3'd6, 2'd1); expect_rsp("r8", UL, 3'd6, 2'd1, OK);
    expect_idle("r8", 4'b0000);
    // rr_last is 6; t4 takes it free, then t6 and t0 queue: wrap picks t0
    send("w1", LK, 3'd4, 2'd1); expect_rsp("w1", LK, 3'd4, 2'd1, OK);
    send("w2", LK, 3'd6, 2'd1); expect_blocked("w2");
    send("w3", LK, 3'd0, 2'd1); expect_blocked("w3");
    send("w4", UL, 3'd4, 2'd1); expect_rsp("w4", UL, 3'd4, 2'd1, OK);
    expect_rsp("w4g", LK, 3'd0, 2'd1, OK);
    send("w5", UL, 3'd0, 2'd1); expect_rsp("w5", UL, 3'd0, 2'd1, OK);
    expect_rsp("w5g", LK, 3'd6, 2'd1, OK);
    send("w6", UL, 3'd6, 2'd1); expect_rsp("w6", UL, 3'd6, 2'd1, OK);
    // only waiter equals rr_last (6)
    send("w7", LK, 3'd2, 2'd1); expect_rsp("w7", LK, 3'd2, 2'd1, OK);
    send("w8", LK, 3'd6, 2'd1); expect_blocked("w8");
    send("w9", UL, 3'd2, 2'd1); expect_rsp("w9", UL, 3'd2, 2'd1, OK);
    expect_rsp("w9g", LK, 3'd6, 2'd1, OK);
    send("wa", UL, 3'd6, 2'd1); expect_rsp("wa", UL, 3'd6, 2'd1, OK);
    expect_idle("wa", 4'b0000);

    // Errors on m3
    send("e1", LK, 3'd4, 2'd3); expect_rsp("e1", LK, 3'd4, 2'd3, OK);
    send("e2", LK, 3'd4, 2'd3); expect_rsp("e2", LK, 3'd4, 2'd3, ERR);
    send("e3", LK, 3'd5, 2'd3); expect_blocked("e3");
    send("e4", LK, 3'd5, 2'd3); expect_rsp("e4", LK, 3'd5, 2'd3, ERR);
    send("e5", RSV, 3'd1, 2'd3); expect_rsp("e5", RSV, 3'd1, 2'd3, ERR);
    expect_idle("e5", 4'b1000);
    send("e6", UL, 3'd4, 2'd3); expect_rsp("e6", UL, 3'd4, 2'd3, OK);
    expect_rsp("e6g", LK, 3'd5, 2'd3, OK);
    send("e7", UL, 3'd5, 2'd3); expect_rsp("e7", UL, 3'd5, 2'd3, OK);
    expect_idle("e7", 4'b0000);

    // Backpressure on both responses of a handoff
    send("p1", LK, 3'd1, 2'd0); expect_rsp("p1", LK, 3'd1, 2'd0, OK);
    send("p2", LK, 3'd2, 2'd0); expect_blocked("p2");
    send("p3", UL, 3'd1, 2'd0);
    hold_rsp("p3", UL, 3'd1, 2'd0, OK);
    expect_rsp("p3", UL, 3'd1, 2'd0, OK);
    hold_rsp("p3g", LK, 3'd2, 2'd0, OK);
    expect_rsp("p3g", LK, 3'd2, 2'd0, OK);
    expect_idle("p3", 4'b0001);
    send("p4", UL, 3'd2, 2'd0); expect_rsp("p4", UL, 3'd2, 2'd0, OK);
    expect_idle("p4", 4'b0000);

    // Reset while a grant is presented
    send("x1", LK, 3'd0, 2'd0); expect_rsp("x1", LK, 3'd0, 2'd0, OK);
    send("x2", LK, 3'd5, 2'd0); expect_blocked("x2");
    send("x3", LK, 3'd6, 2'd2); expect_rsp("x3", LK, 3'd6, 2'd2, OK);
    send("x4", LK, 3'd1, 2'd2); expect_blocked("x4");
    send("x5", UL, 3'd0, 2'd0); expect_rsp("x5", UL, 3'd0, 2'd0, OK);
    @(negedge clock);
    check("x5.grant_valid", 32'(rsp_valid), 32'd1);
    check("x5.grant_tid", 32'(rsp_tid), 32'd5);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("x6.rsp_valid", 32'(rsp_valid), 32'd0);
    check("x6.locked", 32'(mutex_locked), 32'd0);
    check("x6.req_ready", 32'(req_ready), 32'd1);
    $display("rst  x6 mid-grant");
    @(posedge clock); #1;
    send("x7", LK, 3'd0, 2'd0); expect_rsp("x7", LK, 3'd0, 2'd0, OK);
    send("x8", UL, 3'd0, 2'd0); expect_rsp("x8", UL, 3'd0, 2'd0, OK);
    expect_idle("x8", 4'b0000);
    send("x9", LK, 3'd3, 2'd2); expect_rsp("x9", LK, 3'd3, 2'd2, OK);
    send("xa", UL, 3'd3, 2'd2); expect_rsp("xa", UL, 3'd3, 2'd2, OK);
    expect_idle("xa", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
